pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central hazard and sequencing controller for the five-stage CPU pipeline (fetch, decode, execute, memory, writeback). It turns per-stage status into stall, flush and PC-load strobes, and resolves competing events in a fixed priority order. It drains the pipeline on a decoded halt and then raises the sticky `do_halt` seen at CPU top. It also keeps saturating performance counters for stalls and flushes.

## Interface
- `DRAIN_CYCLES`, default 3: cycles needed after halt leaves decode for it to retire (execute, memory, writeback).
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk` in 1: the single clock, rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `dec_valid` in 1: decode holds a real instruction.
- `dec_rs`, `dec_rt` in 4: decode source register addresses.
- `dec_uses_rs`, `dec_uses_rt` in 1: the corresponding source is actually read.
- `dec_is_halt` in 1: the decode instruction is halt (0xFFFF).
- `exe_valid` in 1: execute holds a real instruction.
- `exe_is_mem_read` in 1: the execute instruction is a load.
- `exe_reg_write` in 1: the execute instruction writes a register.
- `exe_rd` in 4: the execute destination register.
- `br_taken` in 1: a branch or jump resolved taken in execute.
- `mem_busy` in 1: data memory cannot complete this cycle.
- `stall_fetch` out 1: PC and fetch register hold.
- `stall_decode` out 1: decode register holds.
- `stall_execute` out 1: execute and memory registers hold.
- `flush_decode` out 1: load a bubble into decode.
- `flush_execute` out 1: load a bubble into execute.
- `pc_load` out 1: PC takes the branch target.
- `do_halt` out 1: registered; sticky until reset.
- `state` out 2: encoding RUN=0, DRAIN=1, HALTED=2.
- `stall_cycles` out CNT_W: saturating count of stall cycles.
- `flush_count` out CNT_W: saturating count of flush events.

## Operation
- All strobes are combinational from the current inputs and the registered `state`. The state, the drain counter and the performance counters are registered.
- `load_use` = `exe_valid & exe_is_mem_read & exe_reg_write & dec_valid & ((dec_uses_rs & dec_rs==exe_rd) | (dec_uses_rt & dec_rt==exe_rd))`. Register 0 is not special.
- In RUN, the first matching rule wins:
  1. `mem_busy`: assert `stall_fetch`, `stall_decode` and `stall_execute`. All other strobes stay 0, so a `br_taken` in the same cycle is deferred and re-presented next cycle.
  2. `br_taken`: assert `pc_load`, `flush_decode` and `flush_execute`. The younger halt, or any younger hazard, is squashed.
  3. `load_use`: assert `stall_fetch` and `stall_decode` and `flush_execute` for this cycle only. The hazard clears naturally once the load advances.
  4. `dec_valid & dec_is_halt`: assert `stall_fetch` and `flush_decode`, enter DRAIN, and clear the drain counter.
  5. Otherwise no strobes are asserted.
- In DRAIN:
  - `stall_fetch` and `flush_decode` are held at 1. `br_taken` and `load_use` are ignored, because only instructions older than halt remain.
  - When `mem_busy` is high, also assert `stall_execute` and freeze the drain counter.
  - Otherwise the counter increments. When it equals `DRAIN_CYCLES-1`, move to HALTED.
- In HALTED: `stall_fetch`, `stall_decode` and `stall_execute` are 1, and `do_halt` is 1. The state is left only by `rst`.
- `stall_cycles` increments on every non-reset cycle in which `stall_fetch` is 1 and the state is not HALTED.
- `flush_count` increments on every `pc_load`. Both counters saturate at all-ones.
- Reset, evaluated at a rising edge with `rst`=1:
  - state goes to RUN, the drain counter, `do_halt` and both performance counters go to 0.
  - While `rst` is high, the combinational outputs are forced to `flush_decode`=`flush_execute`=1 and all others 0.
- A reset during DRAIN or HALTED aborts immediately, with no partial drain.

## Timing
- Strobes take effect on the same cycle: the pipeline registers act on them at the next rising edge.
- `load_use` costs exactly 1 bubble.
- A taken branch costs 2 squashed slots, with PC redirected on the following edge.
- Halt: with `dec_is_halt` in RUN at edge N, `state` is DRAIN after edge N. `do_halt` becomes 1 after edge N+`DRAIN_CYCLES`, plus one cycle for each `mem_busy` cycle during DRAIN.
- `do_halt` never toggles back while `rst`=0.

## Test plan
- Reset, then idle: `state`=0, `do_halt`=0, and after 5 idle cycles all strobes are 0 and both counters are 0.
- Load-use: `exe_is_mem_read` with `exe_rd`=2, `dec_rs`=2 and `dec_uses_rs`=1 for one cycle. Required: `stall_fetch`, `stall_decode` and `flush_execute` equal to 1 for exactly 1 cycle, and `stall_cycles`=1.
- Same case with `dec_uses_rs`=0: no strobes.
- `br_taken` and a halt in decode in the same cycle: `pc_load`=1, `state` stays RUN, and `flush_count`=1.
- `br_taken` together with `mem_busy`: the stall only, with `pc_load` deferred to the next cycle.
- Halt drain, `DRAIN_CYCLES`=3: halt decoded at cycle 10 gives `state`=DRAIN in cycles 11–13 and `do_halt`=1 from cycle 14. Adding `mem_busy` in cycle 12 moves `do_halt` to cycle 15.
- `rst` pulsed in HALTED: after 1 edge, `state`=0 and `do_halt`=0, and normal flow resumes.
- Saturation: force 70000 `mem_busy` cycles and require `stall_cycles`=65535.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/sequencing controller for the five-stage pipeline.
// Turns per-stage status into stall, flush and PC-load strobes, drains on halt
// and keeps saturating stall/flush performance counters.
module pipeline_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [3:0]       dec_rs,
    input  logic [3:0]       dec_rt,
    input  logic             dec_uses_rs,
    input  logic             dec_uses_rt,
    input  logic             dec_is_halt,
    input  logic             exe_valid,
    input  logic             exe_is_mem_read,
    input  logic             exe_reg_write,
    input  logic [3:0]       exe_rd,
    input  logic             br_taken,
    input  logic             mem_busy,
    output logic             stall_fetch,
    output logic             stall_decode,
    output logic             stall_execute,
    output logic             flush_decode,
    output logic             flush_execute,
    output logic             pc_load,
    output logic             do_halt,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              do_halt_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;
    logic              load_use;

    // Load in execute feeding a source register that decode actually reads
    assign load_use = exe_valid & exe_is_mem_read & exe_reg_write & dec_valid &
                      ((dec_uses_rs & (dec_rs == exe_rd)) |
                       (dec_uses_rt & (dec_rt == exe_rd)));

    // Next-state and strobe decode, fixed priority within RUN
    always_comb begin
        state_d       = state_q;
        dcnt_d        = dcnt_q;
        stall_fetch   = 1'b0;
        stall_decode  = 1'b0;
        stall_execute = 1'b0;
        flush_decode  = 1'b0;
        flush_execute = 1'b0;
        pc_load       = 1'b0;
        if (rst) begin
            flush_decode  = 1'b1;
            flush_execute = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_busy) begin
                        stall_fetch   = 1'b1;
                        stall_decode  = 1'b1;
                        stall_execute = 1'b1;
                    end else if (br_taken) begin
                        pc_load       = 1'b1;
                        flush_decode  = 1'b1;
                        flush_execute = 1'b1;
                    end else if (load_use) begin
                        stall_fetch   = 1'b1;
                        stall_decode  = 1'b1;
                        flush_execute = 1'b1;
                    end else if (dec_valid & dec_is_halt) begin
                        stall_fetch  = 1'b1;
                        flush_decode = 1'b1;
                        state_d      = DRAIN;
                        dcnt_d       = '0;
                    end
                end
                DRAIN: begin
                    stall_fetch  = 1'b1;
                    flush_decode = 1'b1;
                    if (mem_busy) begin
                        stall_execute = 1'b1;
                    end else if (dcnt_q == DRAIN_LAST) begin
                        state_d = HALTED;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
                HALTED: begin
                    stall_fetch   = 1'b1;
                    stall_decode  = 1'b1;
                    stall_execute = 1'b1;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // State, drain counter, sticky halt flag and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            dcnt_q      <= '0;
            do_halt_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            if (state_d == HALTED) begin
                do_halt_q <= 1'b1;
            end
            if (stall_fetch && (state_q != HALTED) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (pc_load && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign do_halt      = do_halt_q;
    assign state        = state_q;
    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: scoreboard of expected strobes and
// registered status, compared at the falling edge of each cycle.
module tb_pipeline_ctrl;

    localparam int CW = 16;

    localparam logic [5:0] S_NONE       = 6'b000000; // {sf,sd,se,fd,fe,pl}
    localparam logic [5:0] S_BUSY       = 6'b111000;
    localparam logic [5:0] S_BR         = 6'b000111;
    localparam logic [5:0] S_LU         = 6'b110010;
    localparam logic [5:0] S_HALT       = 6'b100100;
    localparam logic [5:0] S_DRAIN      = 6'b100100;
    localparam logic [5:0] S_DRAIN_BUSY = 6'b101100;
    localparam logic [5:0] S_HALTED     = 6'b111000;
    localparam logic [5:0] S_RST        = 6'b000110;
    localparam logic [1:0] ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_HALTED = 2'd2;

    typedef struct packed {
        logic       rst;
        logic       dv;
        logic [3:0] rs;
        logic [3:0] rt;
        logic       urs;
        logic       urt;
        logic       halt;
        logic       ev;
        logic       mr;
        logic       rw;
        logic [3:0] rd;
        logic       br;
        logic       busy;
    } stim_t;

    typedef struct packed {
        stim_t      s;
        logic [5:0] strb;
        logic [1:0] st;
        logic       dh;
    } step_t;

    typedef struct packed {
        logic [5:0]    strb;
        logic [1:0]    st;
        logic          dh;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, dec_valid, dec_uses_rs, dec_uses_rt, dec_is_halt;
    logic [3:0]    dec_rs, dec_rt, exe_rd;
    logic          exe_valid, exe_is_mem_read, exe_reg_write, br_taken, mem_busy;
    logic          stall_fetch, stall_decode, stall_execute;
    logic          flush_decode, flush_execute, pc_load, do_halt;
    logic [1:0]    state;
    logic [CW-1:0] stall_cycles, flush_count;

    exp_t sb_q[$];
    exp_t got;
    int   checks = 0;
    int   errors = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    wire [5:0]  obs_strb = {stall_fetch, stall_decode, stall_execute,
                            flush_decode, flush_execute, pc_load};
    wire [34:0] obs_regs = {state, do_halt, stall_cycles, flush_count};

    pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt),
        .dec_is_halt(dec_is_halt), .exe_valid(exe_valid),
        .exe_is_mem_read(exe_is_mem_read), .exe_reg_write(exe_reg_write),
        .exe_rd(exe_rd), .br_taken(br_taken), .mem_busy(mem_busy),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode),
        .stall_execute(stall_execute), .flush_decode(flush_decode),
        .flush_execute(flush_execute), .pc_load(pc_load), .do_halt(do_halt),
        .state(state), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    function automatic stim_t idle_s();
        stim_t s = '0;
        return s;
    endfunction

    function automatic stim_t lu_s(input logic [3:0] rd, input logic [3:0] rs,
                                   input logic urs, input logic [3:0] rt, input logic urt);
        stim_t s = '0;
        s.ev = 1'b1; s.mr = 1'b1; s.rw = 1'b1; s.rd = rd;
        s.dv = 1'b1; s.rs = rs; s.urs = urs; s.rt = rt; s.urt = urt;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        rst = s.rst; dec_valid = s.dv; dec_rs = s.rs; dec_rt = s.rt;
        dec_uses_rs = s.urs; dec_uses_rt = s.urt; dec_is_halt = s.halt;
        exe_valid = s.ev; exe_is_mem_read = s.mr; exe_reg_write = s.rw;
        exe_rd = s.rd; br_taken = s.br; mem_busy = s.busy;
    endtask

    // Queue the expectation for this cycle, then advance the counter model
    task automatic sb_push(input logic [5:0] strb, input logic [1:0] st,
                           input logic dh, input logic r);
        sb_q.push_back('{strb, st, dh, CW'(exp_stall), CW'(exp_flush)});
        if (r) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (strb[5] && st != ST_HALTED && exp_stall < 65535) exp_stall++;
            if (strb[0] && exp_flush < 65535) exp_flush++;
        end
    endtask

    task automatic test_reset();
        step_t t[6];
        stim_t s;
        s = idle_s(); s.rst = 1'b1;
        t[0] = '{s, S_RST, ST_RUN, 1'b0};
        for (int i = 1; i < 6; i++) t[i] = '{idle_s(), S_NONE, ST_RUN, 1'b0};
        for (int i = 0; i < 6; i++) begin
            apply(t[i].s);
            sb_push(t[i].strb, t[i].st, t[i].dh, t[i].s.rst);
            @(negedge clk);
            got = sb_q.pop_front();
            checks++;
            if (obs_strb !== got.strb) begin
                errors++;
                $display("FAIL reset[%0d] strobes got=%b exp=%b", i, obs_strb, got.strb);
            end
            checks++;
            if (obs_regs !== {got.st, got.dh, got.sc, got.fc}) begin
                errors++;
                $display("FAIL reset[%0d] state/halt/stalls/flushes got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d",
                         i, state, do_halt, stall_cycles, flush_count, got.st, got.dh, got.sc, got.fc);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        step_t t[8];
        stim_t s;
        t[0] = '{lu_s(4'd2, 4'd2, 1'b1, 4'd0, 1'b0), S_LU, ST_RUN, 1'b0};
        t[1] = '{idle_s(), S_NONE, ST_RUN, 1'b0};
        t[2] = '{lu_s(4'd2, 4'd2, 1'b0, 4'd0, 1'b0), S_NONE, ST_RUN, 1'b0};
        t[3] = '{lu_s(4'd7, 4'd5, 1'b1, 4'd7, 1'b1), S_LU, ST_RUN, 1'b0};
        t[4] = '{lu_s(4'd0, 4'd0, 1'b1, 4'd3, 1'b0), S_LU, ST_RUN, 1'b0};
        t[5] = '{lu_s(4'd2, 4'd3, 1'b1, 4'd2, 1'b0), S_NONE, ST_RUN, 1'b0};
        s = lu_s(4'd4, 4'd4, 1'b1, 4'd4, 1'b1); s.rw = 1'b0;
        t[6] = '{s, S_NONE, ST_RUN, 1'b0};
        s = lu_s(4'd4, 4'd4, 1'b1, 4'd4, 1'b1); s.dv = 1'b0;
        t[7] = '{s, S_NONE, ST_RUN, 1'b0};
        for (int i = 0; i < 8; i++) begin
            apply(t[i].s);
            sb_push(t[i].strb, t[i].st, t[i].dh, t[i].s.rst);
            @(negedge clk);
            got = sb_q.pop_front();
            checks++;
            if (obs_strb !== got.strb) begin
                errors++;
                $display("FAIL load_use[%0d] strobes got=%b exp=%b", i, obs_strb, got.strb);
            end
            checks++;
            if (obs_regs !== {got.st, got.dh, got.sc, got.fc}) begin
                errors++;
                $display("FAIL load_use[%0d] state/halt/stalls/flushes got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d",
                         i, state, do_halt, stall_cycles, flush_count, got.st, got.dh, got.sc, got.fc);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_priority();
        step_t t[8];
        stim_t s;
        s = idle_s(); s.br = 1'b1; s.dv = 1'b1; s.halt = 1'b1;
        t[0] = '{s, S_BR, ST_RUN, 1'b0};
        t[1] = '{idle_s(), S_NONE, ST_RUN, 1'b0};
        s = idle_s(); s.br = 1'b1; s.busy = 1'b1;
        t[2] = '{s, S_BUSY, ST_RUN, 1'b0};
        s = idle_s(); s.br = 1'b1;
        t[3] = '{s, S_BR, ST_RUN, 1'b0};
        s = lu_s(4'd9, 4'd9, 1'b1, 4'd0, 1'b0); s.busy = 1'b1;
        t[4] = '{s, S_BUSY, ST_RUN, 1'b0};
        s = lu_s(4'd9, 4'd9, 1'b1, 4'd0, 1'b0); s.br = 1'b1;
        t[5] = '{s, S_BR, ST_RUN, 1'b0};
        s = lu_s(4'd6, 4'd0, 1'b0, 4'd6, 1'b1); s.halt = 1'b1;
        t[6] = '{s, S_LU, ST_RUN, 1'b0};
        t[7] = '{idle_s(), S_NONE, ST_RUN, 1'b0};
        for (int i = 0; i < 8; i++) begin
            apply(t[i].s);
            sb_push(t[i].strb, t[i].st, t[i].dh, t[i].s.rst);
            @(negedge clk);
            got = sb_q.pop_front();
            checks++;
            if (obs_strb !== got.strb) begin
                errors++;
                $display("FAIL priority[%0d] strobes got=%b exp=%b", i, obs_strb, got.strb);
            end
            checks++;
            if (obs_regs !== {got.st, got.dh, got.sc, got.fc}) begin
                errors++;
                $display("FAIL priority[%0d] state/halt/stalls/flushes got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d",
                         i, state, do_halt, stall_cycles, flush_count, got.st, got.dh, got.sc, got.fc);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt_drain();
        step_t t[10];
        stim_t s;
        s = idle_s(); s.dv = 1'b1; s.halt = 1'b1;
        t[0] = '{s, S_HALT, ST_RUN, 1'b0};
        s = lu_s(4'd1, 4'd1, 1'b1, 4'd0, 1'b0); s.br = 1'b1;
        t[1] = '{s, S_DRAIN, ST_DRAIN, 1'b0};
        t[2] = '{idle_s(), S_DRAIN, ST_DRAIN, 1'b0};
        t[3] = '{idle_s(), S_DRAIN, ST_DRAIN, 1'b0};
        t[4] = '{idle_s(), S_HALTED, ST_HALTED, 1'b1};
        s = idle_s(); s.br = 1'b1; s.busy = 1'b1;
        t[5] = '{s, S_HALTED, ST_HALTED, 1'b1};
        t[6] = '{idle_s(), S_HALTED, ST_HALTED, 1'b1};
        s = idle_s(); s.rst = 1'b1;
        t[7] = '{s, S_RST, ST_HALTED, 1'b1};
        t[8] = '{idle_s(), S_NONE, ST_RUN, 1'b0};
        t[9] = '{lu_s(4'd3, 4'd3, 1'b1, 4'd0, 1'b0), S_LU, ST_RUN, 1'b0};
        for (int i = 0; i < 10; i++) begin
            apply(t[i].s);
            sb_push(t[i].strb, t[i].st, t[i].dh, t[i].s.rst);
            @(negedge clk);
            got = sb_q.pop_front();
            checks++;
            if (obs_strb !== got.strb) begin
                errors++;
                $display("FAIL halt_drain[%0d] strobes got=%b exp=%b", i, obs_strb, got.strb);
            end
            checks++;
            if (obs_regs !== {got.st, got.dh, got.sc, got.fc}) begin
                errors++;
                $display("FAIL halt_drain[%0d] state/halt/stalls/flushes got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d",
                         i, state, do_halt, stall_cycles, flush_count, got.st, got.dh, got.sc, got.fc);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt_busy();
        step_t t[8];
        stim_t s;
        s = idle_s(); s.dv = 1'b1; s.halt = 1'b1;
        t[0] = '{s, S_HALT, ST_RUN, 1'b0};
        t[1] = '{idle_s(), S_DRAIN, ST_DRAIN, 1'b0};
        s = idle_s(); s.busy = 1'b1;
        t[2] = '{s, S_DRAIN_BUSY, ST_DRAIN, 1'b0};
        t[3] = '{idle_s(), S_DRAIN, ST_DRAIN, 1'b0};
        t[4] = '{idle_s(), S_DRAIN, ST_DRAIN, 1'b0};
        t[5] = '{idle_s(), S_HALTED, ST_HALTED, 1'b1};
        s = idle_s(); s.rst = 1'b1;
        t[6] = '{s, S_RST, ST_HALTED, 1'b1};
        t[7] = '{idle_s(), S_NONE, ST_RUN, 1'b0};
        for (int i = 0; i < 8; i++) begin
            apply(t[i].s);
            sb_push(t[i].strb, t[i].st, t[i].dh, t[i].s.rst);
            @(negedge clk);
            got = sb_q.pop_front();
            checks++;
            if (obs_strb !== got.strb) begin
                errors++;
                $display("FAIL halt_busy[%0d] strobes got=%b exp=%b", i, obs_strb, got.strb);
            end
            checks++;
            if (obs_regs !== {got.st, got.dh, got.sc, got.fc}) begin
                errors++;
                $display("FAIL halt_busy[%0d] state/halt/stalls/flushes got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d",
                         i, state, do_halt, stall_cycles, flush_count, got.st, got.dh, got.sc, got.fc);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        stim_t s;
        s = idle_s(); s.busy = 1'b1;
        apply(s);
        for (int i = 0; i < 70000; i++) begin
            sb_push(S_BUSY, ST_RUN, 1'b0, 1'b0);
            void'(sb_q.pop_back());
            @(posedge clk); #1;
        end
        sb_push(S_BUSY, ST_RUN, 1'b0, 1'b0);
        @(negedge clk);
        got = sb_q.pop_front();
        checks++;
        if (stall_cycles !== got.sc || got.sc !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturation stall_cycles got=%0d exp=%0d", stall_cycles, got.sc);
        end
        checks++;
        if (obs_strb !== got.strb || flush_count !== got.fc) begin
            errors++;
            $display("FAIL saturation strobes/flushes got=%b/%0d exp=%b/%0d",
                     obs_strb, flush_count, got.strb, got.fc);
        end
        @(posedge clk); #1;
        apply(idle_s());
    endtask

    initial begin
        s_init();
        test_reset();
        test_load_use();
        test_priority();
        test_halt_drain();
        test_halt_busy();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic s_init();
        stim_t s;
        s = idle_s(); s.rst = 1'b1;
        apply(s);
        @(posedge clk); #1;
    endtask

endmodule
